// File: rtl/writeback_arbiter.sv
// writeback_arbiter: per-channel result FIFOs feeding a single register-file write port.
// Define WB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (highest channel wins).
module writeback_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     async_rst_n,
  input  logic                     clk_en,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH*ADDR_W-1:0] in_dest,
  output logic                     wb_en,
  output logic [DATA_W-1:0]        wb_data,
  output logic [ADDR_W-1:0]        wb_dest,
  output logic [NUM_CH-1:0]        wb_grant,
  output logic [(2**ADDR_W)-1:0]   pending_mask,
  output logic                     empty
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_W-1:0] mem_data [NUM_CH][DEPTH];
  logic [ADDR_W-1:0] mem_dest [NUM_CH][DEPTH];
  logic [DEPTH-1:0]  ent_vld  [NUM_CH];
  logic [CNT_W-1:0]  count    [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr   [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr   [NUM_CH];

  logic [NUM_CH-1:0] head_vld;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [CH_W-1:0]   grant_idx;
  logic              any_head;

  // Writes to register 0 complete the handshake but are never stored.
  always_comb begin
    in_ready = '0;
    push     = '0;
    head_vld = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = clk_en && !flush && (count[i] < CNT_W'(DEPTH));
      push[i]     = in_valid[i] && in_ready[i] && (in_dest[i*ADDR_W +: ADDR_W] != '0);
      head_vld[i] = (count[i] != '0);
    end
  end

  assign any_head = |head_vld;

`ifdef WB_ROUND_ROBIN_EN
  logic [CH_W-1:0] last_grant;
  logic            found;
  int              idx;

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant) + k) % NUM_CH;
      if (!found && head_vld[idx]) begin
        found     = 1'b1;
        grant_idx = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (clk_en) begin
      if (flush)
        last_grant <= CH_W'(NUM_CH - 1);
      else if (any_head)
        last_grant <= grant_idx;
    end
  end
`else
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (head_vld[i]) grant_idx = CH_W'(i);
  end
`endif

  assign wb_en    = any_head;
  assign empty    = ~any_head;
  assign wb_grant = any_head ? (NUM_CH'(1) << grant_idx) : '0;
  assign pop      = (any_head && clk_en && !flush) ? (NUM_CH'(1) << grant_idx) : '0;
  assign wb_data  = any_head ? mem_data[grant_idx][rd_ptr[grant_idx]] : '0;
  assign wb_dest  = any_head ? mem_dest[grant_idx][rd_ptr[grant_idx]] : '0;

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_CH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (ent_vld[i][j]) pending_mask[mem_dest[i][j]] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  // A push never lands on the slot being popped: push needs count<DEPTH, pop needs count>0.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count[i]   <= '0;
        rd_ptr[i]  <= '0;
        wr_ptr[i]  <= '0;
        ent_vld[i] <= '0;
      end
    end else if (clk_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (flush) begin
          count[i]   <= '0;
          rd_ptr[i]  <= '0;
          wr_ptr[i]  <= '0;
          ent_vld[i] <= '0;
        end else begin
          if (pop[i]) begin
            rd_ptr[i]              <= rd_ptr[i] + PTR_W'(1);
            ent_vld[i][rd_ptr[i]]  <= 1'b0;
          end
          if (push[i]) begin
            wr_ptr[i]              <= wr_ptr[i] + PTR_W'(1);
            ent_vld[i][wr_ptr[i]]  <= 1'b1;
          end
          case ({push[i], pop[i]})
            2'b10:   count[i] <= count[i] + CNT_W'(1);
            2'b01:   count[i] <= count[i] - CNT_W'(1);
            default: count[i] <= count[i];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        mem_data[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
        mem_dest[i][wr_ptr[i]] <= in_dest[i*ADDR_W +: ADDR_W];
      end
    end
  end
endmodule
